// File: rtl/fp32_div_sched_if.sv
// Handshake and core-side bundle for fp32_div_sched: two requesters, one response
// channel and the shared divider core operands/result.
interface fp32_div_sched_if #(
  parameter int TAG_W = 4
);
  // Valid/ready: a transfer happens on a rising clk edge where valid && ready are both
  // high; the source keeps valid and its payload stable until that edge, and ready may
  // depend combinationally on valid.
  logic             req0_valid;
  logic             req0_ready;
  logic [31:0]      req0_a;
  logic [31:0]      req0_b;
  logic [TAG_W-1:0] req0_tag;

  logic             req1_valid;
  logic             req1_ready;
  logic [31:0]      req1_a;
  logic [31:0]      req1_b;
  logic [TAG_W-1:0] req1_tag;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_q;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_src;
  logic [2:0]       rsp_flags;

  logic             core_start;
  logic [31:0]      core_dividend;
  logic [31:0]      core_divisor;
  logic [31:0]      core_quotient;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_tag,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_tag,
    output req1_ready,
    output rsp_valid, rsp_q, rsp_tag, rsp_src, rsp_flags,
    input  rsp_ready,
    output core_start, core_dividend, core_divisor,
    input  core_quotient
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_tag,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_tag,
    input  req1_ready,
    input  rsp_valid, rsp_q, rsp_tag, rsp_src, rsp_flags,
    output rsp_ready,
    input  core_start, core_dividend, core_divisor,
    output core_quotient
  );
endinterface

// File: rtl/fp32_div_sched.sv
// Round-robin sequencer sharing one iterative FP32 divider core between two requesters.
// Optional FP32_DIV_SPECIAL_EN resolves special operands at accept without using the core.
module fp32_div_sched #(
  parameter int DIV_LAT = 15,
  parameter int TAG_W   = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  fp32_div_sched_if.slave     bus,
  output logic                busy_o,
  output logic [1:0]          dbg_state_o
);

  localparam int CNT_W = $clog2(DIV_LAT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             last_q;
  logic [TAG_W-1:0] tag_q;
  logic             src_q;
  logic             core_start_q;
  logic [31:0]      core_dividend_q;
  logic [31:0]      core_divisor_q;
  logic             rsp_valid_q;
  logic [31:0]      rsp_quot_q;
  logic [TAG_W-1:0] rsp_tag_q;
  logic             rsp_src_q;
  logic [2:0]       rsp_flags_q;

  logic             idle_gnt;
  logic             any_valid;
  logic             gnt_src;
  logic [31:0]      sel_a;
  logic [31:0]      sel_b;
  logic [TAG_W-1:0] sel_tag;

  logic             spec_hit;
  logic             spec_nv;
  logic             spec_dz;
  logic [31:0]      spec_res;

  // Ties go to the requester that did not win last; a lone requester always wins.
  assign any_valid = bus.req0_valid | bus.req1_valid;
  assign gnt_src   = (bus.req0_valid & bus.req1_valid) ? ~last_q : bus.req1_valid;
  assign idle_gnt  = rst_ni & (state_q == S_IDLE);

  assign bus.req0_ready = idle_gnt & bus.req0_valid & ~gnt_src;
  assign bus.req1_ready = idle_gnt & bus.req1_valid &  gnt_src;

  assign sel_a   = gnt_src ? bus.req1_a   : bus.req0_a;
  assign sel_b   = gnt_src ? bus.req1_b   : bus.req0_b;
  assign sel_tag = gnt_src ? bus.req1_tag : bus.req0_tag;

`ifdef FP32_DIV_SPECIAL_EN
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, q_sign;

  assign a_nan  = (sel_a[30:23] == 8'hFF) && (sel_a[22:0] != 23'd0);
  assign b_nan  = (sel_b[30:23] == 8'hFF) && (sel_b[22:0] != 23'd0);
  assign a_inf  = (sel_a[30:23] == 8'hFF) && (sel_a[22:0] == 23'd0);
  assign b_inf  = (sel_b[30:23] == 8'hFF) && (sel_b[22:0] == 23'd0);
  assign a_zero = (sel_a[30:0] == 31'd0);
  assign b_zero = (sel_b[30:0] == 31'd0);
  assign q_sign = sel_a[31] ^ sel_b[31];

  // Invalid cases first, so 0/0 and inf/inf never fall into the dz or inf branches.
  always_comb begin
    spec_hit = 1'b0;
    spec_nv  = 1'b0;
    spec_dz  = 1'b0;
    spec_res = 32'd0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_hit = 1'b1;
      spec_nv  = 1'b1;
      spec_res = 32'h7FC0_0000;
    end else if (b_zero) begin
      spec_hit = 1'b1;
      spec_dz  = 1'b1;
      spec_res = {q_sign, 8'hFF, 23'd0};
    end else if (a_inf) begin
      spec_hit = 1'b1;
      spec_res = {q_sign, 8'hFF, 23'd0};
    end else if (a_zero || b_inf) begin
      spec_hit = 1'b1;
      spec_res = {q_sign, 31'd0};
    end
  end
`else
  assign spec_hit = 1'b0;
  assign spec_nv  = 1'b0;
  assign spec_dz  = 1'b0;
  assign spec_res = 32'd0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      last_q          <= 1'b1;
      tag_q           <= '0;
      src_q           <= 1'b0;
      core_start_q    <= 1'b0;
      core_dividend_q <= 32'd0;
      core_divisor_q  <= 32'd0;
      rsp_valid_q     <= 1'b0;
      rsp_quot_q      <= 32'd0;
      rsp_tag_q       <= '0;
      rsp_src_q       <= 1'b0;
      rsp_flags_q     <= 3'd0;
    end else begin
      core_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (any_valid) begin
            last_q          <= gnt_src;
            tag_q           <= sel_tag;
            src_q           <= gnt_src;
            core_dividend_q <= sel_a;
            core_divisor_q  <= sel_b;
            if (spec_hit) begin
              rsp_valid_q <= 1'b1;
              rsp_quot_q  <= spec_res;
              rsp_tag_q   <= sel_tag;
              rsp_src_q   <= gnt_src;
              rsp_flags_q <= {spec_nv, spec_dz, 1'b1};
              state_q     <= S_DONE;
            end else begin
              core_start_q <= 1'b1;
              state_q      <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          cnt_q   <= CNT_W'(DIV_LAT - 1);
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // cnt reaches 0 in the cycle the core presents its quotient.
          if (cnt_q == '0) begin
            rsp_valid_q <= 1'b1;
            rsp_quot_q  <= bus.core_quotient;
            rsp_tag_q   <= tag_q;
            rsp_src_q   <= src_q;
            rsp_flags_q <= 3'd0;
            state_q     <= S_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_DONE: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.core_start    = core_start_q;
  assign bus.core_dividend = core_dividend_q;
  assign bus.core_divisor  = core_divisor_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_q         = rsp_quot_q;
  assign bus.rsp_tag       = rsp_tag_q;
  assign bus.rsp_src       = rsp_src_q;
  assign bus.rsp_flags     = rsp_flags_q;
  assign busy_o            = (state_q != S_IDLE);
  assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_fp32_div_sched.sv
// Randomized and directed bench for fp32_div_sched against a cycle-timeline reference
// model; define FP32_DIV_SPECIAL_EN for both RTL and bench to cover the bypass path.
module tb_fp32_div_sched;

  localparam int DIV_LAT = 15;
  localparam int TAG_W   = 4;
  localparam int EW      = 32 + TAG_W + 1 + 3;

  logic       clk;
  logic       rst_n;
  logic       busy;
  logic [1:0] dbg_state;

  fp32_div_sched_if #(.TAG_W(TAG_W)) bus ();

  fp32_div_sched #(.DIV_LAT(DIV_LAT), .TAG_W(TAG_W)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .bus         (bus),
    .busy_o      (busy),
    .dbg_state_o (dbg_state)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- stand-in divider core ----------------
  // Quotient is only meaningful exactly DIV_LAT cycles after the start cycle.
  function automatic logic [31:0] core_fn(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h3F800000_40000000: core_fn = 32'h3F00_0000;
      64'h40C00000_40400000: core_fn = 32'h4000_0000;
      default:               core_fn = a ^ {b[7:0], b[31:8]} ^ 32'h1234_5678;
    endcase
  endfunction

  int          cyc     = 0;
  int          core_st = -1000;
  logic [31:0] core_a  = 32'd0;
  logic [31:0] core_b  = 32'd0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.core_start) begin
      core_st <= cyc;
      core_a  <= bus.core_dividend;
      core_b  <= bus.core_divisor;
    end
  end

  assign bus.core_quotient = (cyc == core_st + DIV_LAT) ? core_fn(core_a, core_b)
                                                        : (32'(cyc) ^ 32'hDEAD_BEEF);

  // ---------------- reference model of special-operand handling ----------------
  // Returns {hit, nv, dz, result}.
  function automatic logic [34:0] spec_model(input logic [31:0] a, input logic [31:0] b);
    logic [34:0] r;
    r = '0;
`ifdef FP32_DIV_SPECIAL_EN
    begin
      bit an, bn, ai, bi, az, bz;
      logic s;
      an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
      bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
      ai = (a[30:23] == 8'hFF) && (a[22:0] == 0);
      bi = (b[30:23] == 8'hFF) && (b[22:0] == 0);
      az = (a[30:0] == 0);
      bz = (b[30:0] == 0);
      s  = a[31] ^ b[31];
      if (an || bn || (az && bz) || (ai && bi)) r = {3'b110, 32'h7FC0_0000};
      else if (bz)                              r = {3'b101, s, 31'h7F80_0000};
      else if (ai)                              r = {3'b100, s, 31'h7F80_0000};
      else if (az || bi)                        r = {3'b100, s, 31'd0};
    end
`endif
    return r;
  endfunction

  // ---------------- scoreboard / per-cycle compare ----------------
  logic [EW-1:0] exp_q[$];
  bit            m_idle     = 1'b1;
  bit            m_last     = 1'b1;
  bit            m_byp      = 1'b0;
  int            m_start_at = -1;
  int            m_rsp_at   = 0;
  logic [31:0]   m_a, m_b;
  bit            acc0 = 1'b0;
  bit            acc1 = 1'b0;

  bit            gsrc;
  logic [4:0]    ctl_exp;
  logic [34:0]   sp;
  logic [TAG_W-1:0] m_tag;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_outputs",
            {bus.req0_ready, bus.req1_ready, bus.core_start, bus.rsp_valid, busy,
             bus.rsp_q, bus.rsp_tag, bus.rsp_src, bus.rsp_flags}, '0);
      check("reset_core_ops", {bus.core_dividend, bus.core_divisor}, '0);
      m_idle = 1'b1; m_last = 1'b1; m_start_at = -1;
      exp_q.delete();
      acc0 = 1'b0; acc1 = 1'b0;
    end else begin
      gsrc    = (bus.req0_valid && bus.req1_valid) ? !m_last : bus.req1_valid;
      ctl_exp = {m_idle && bus.req0_valid && !gsrc,
                 m_idle && bus.req1_valid && gsrc,
                 !m_idle && (cyc == m_start_at),
                 !m_idle && (cyc >= m_rsp_at),
                 !m_idle};
      check("ctl{rdy0,rdy1,start,rv,busy}",
            {bus.req0_ready, bus.req1_ready, bus.core_start, bus.rsp_valid, busy}, ctl_exp);
      if (ctl_exp[1]) begin
        if (exp_q.size() == 0) check("rsp_expected", 1'b0, 1'b1);
        else check("rsp{q,tag,src,flags}",
                   {bus.rsp_q, bus.rsp_tag, bus.rsp_src, bus.rsp_flags}, exp_q[0]);
      end
      if (!m_idle && !m_byp && cyc >= m_start_at && cyc < m_rsp_at)
        check("core_operands", {bus.core_dividend, bus.core_divisor}, {m_a, m_b});

      acc0 = bus.req0_valid && bus.req0_ready;
      acc1 = bus.req1_valid && bus.req1_ready;

      if (m_idle) begin
        if (bus.req0_valid || bus.req1_valid) begin
          m_last = gsrc;
          m_a    = gsrc ? bus.req1_a   : bus.req0_a;
          m_b    = gsrc ? bus.req1_b   : bus.req0_b;
          m_tag  = gsrc ? bus.req1_tag : bus.req0_tag;
          sp     = spec_model(m_a, m_b);
          m_idle = 1'b0;
          if (sp[34]) begin
            m_byp = 1'b1; m_start_at = -1; m_rsp_at = cyc + 1;
            exp_q.push_back({sp[31:0], m_tag, gsrc, sp[33], sp[32], 1'b1});
          end else begin
            m_byp = 1'b0; m_start_at = cyc + 1; m_rsp_at = cyc + 2 + DIV_LAT;
            exp_q.push_back({core_fn(m_a, m_b), m_tag, gsrc, 3'b000});
          end
        end
      end else if (cyc >= m_rsp_at && bus.rsp_ready) begin
        m_idle = 1'b1;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_req(input int src, input logic [31:0] a, input logic [31:0] b,
                           input logic [TAG_W-1:0] tag);
    if (src == 0) begin
      bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_tag = tag;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_tag = tag;
    end
  endtask

  task automatic wait_acc(output int src);
    int n = 0;
    bit got = 1'b0;
    src = -1;
    while (!got && n < 200) begin
      @(negedge clk);
      n++;
      if (bus.req0_valid && bus.req0_ready) begin got = 1'b1; src = 0; end
      else if (bus.req1_valid && bus.req1_ready) begin got = 1'b1; src = 1; end
    end
    check("accept_seen", got, 1'b1);
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.rsp_valid && n < 200);
    check("rsp_seen", bus.rsp_valid, 1'b1);
  endtask

  task automatic drain();
    int n = 0;
    bus.rsp_ready = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || bus.rsp_valid) && n < 200);
    check("drain_idle", {busy, bus.rsp_valid}, 2'b00);
  endtask

  function automatic logic [31:0] rand_op();
`ifdef FP32_DIV_SPECIAL_EN
    logic [31:0] tbl [9];
    tbl = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000,
            32'h7F80_0001, 32'h3F80_0000, 32'hC040_0000, 32'h0000_0001};
    if ($urandom_range(0, 1) == 1) return tbl[$urandom_range(0, 8)];
`endif
    return $urandom;
  endfunction

  // ---------------- directed + random stimulus ----------------
  int src, n;

  initial begin
    rst_n = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_tag = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_tag = '0;
    bus.rsp_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Round robin from reset: both held valid for four divides.
    @(posedge clk); #1;
    drive_req(0, 32'h3F80_0000, 32'h4000_0000, 4'd1);
    drive_req(1, 32'h40C0_0000, 32'h4040_0000, 4'd2);
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_acc(src);
      check("rr_order", 64'(src), 64'(i % 2));
    end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    drain();

    // 1.0 / 2.0 from req0, then backpressure for 10 cycles with req1 waiting.
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    drive_req(0, 32'h3F80_0000, 32'h4000_0000, 4'd3);
    wait_acc(src);
    check("t1_src", 64'(src), 64'd0);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    drive_req(1, 32'h1234_5678, 32'h3F80_0000, 4'd7);
    wait_rsp(n);
    check("t1_latency", 64'(n), 64'(DIV_LAT + 2));
    check("t1_rsp", {bus.rsp_q, bus.rsp_tag, bus.rsp_src}, {32'h3F00_0000, 4'd3, 1'b0});
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_stable",
            {bus.rsp_valid, bus.rsp_q, bus.rsp_tag, bus.rsp_src, bus.rsp_flags,
             bus.req0_ready, bus.req1_ready},
            {1'b1, 32'h3F00_0000, 4'd3, 1'b0, 3'b000, 2'b00});
    end
    @(posedge clk); #1 bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("idle_after_rsp", {busy, bus.req1_ready}, 2'b01);
    @(posedge clk); #1 bus.req1_valid = 1'b0;
    drain();

    // 6 / 3 with busy tracking.
    @(posedge clk); #1;
    drive_req(0, 32'h40C0_0000, 32'h4040_0000, 4'd5);
    wait_acc(src);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    check("t6_busy_at_issue", busy, 1'b1);
    wait_rsp(n);
    check("t6_quot", bus.rsp_q, 32'h4000_0000);
    drain();

    // Reset in the middle of WAIT; afterwards a lone req1 is granted.
    @(posedge clk); #1;
    drive_req(0, 32'h4120_0000, 32'h4000_0000, 4'd9);
    wait_acc(src);
    @(posedge clk); #1 bus.req0_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    drive_req(1, 32'h4100_0000, 32'h4080_0000, 4'd4);
    rst_n = 1'b0;
    #1;
    check("rst_immediate",
          {busy, bus.rsp_valid, bus.core_start, bus.req0_ready, bus.req1_ready}, 5'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check("post_rst_grant", {bus.req0_ready, bus.req1_ready}, 2'b01);
    @(posedge clk); #1 bus.req1_valid = 1'b0;
    drain();

`ifdef FP32_DIV_SPECIAL_EN
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    drive_req(0, 32'hBF80_0000, 32'h0000_0000, 4'd2);
    wait_acc(src);
    @(posedge clk); #1 bus.req0_valid = 1'b0;
    wait_rsp(n);
    check("byp_dz_latency", 64'(n), 64'd1);
    check("byp_dz", {bus.rsp_q, bus.rsp_flags}, {32'hFF80_0000, 3'b011});
    drain();

    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    drive_req(1, 32'h7FC0_0000, 32'h3F80_0000, 4'd6);
    wait_acc(src);
    @(posedge clk); #1 bus.req1_valid = 1'b0;
    wait_rsp(n);
    check("byp_nan", {bus.rsp_q, bus.rsp_flags, bus.rsp_src}, {32'h7FC0_0000, 3'b101, 1'b1});
    drain();
`endif

    // Random traffic with random backpressure.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (!bus.req0_valid || acc0) begin
        bus.req0_valid = ($urandom_range(0, 2) != 0);
        bus.req0_a = rand_op(); bus.req0_b = rand_op();
        bus.req0_tag = TAG_W'($urandom_range(0, (1 << TAG_W) - 1));
      end
      if (!bus.req1_valid || acc1) begin
        bus.req1_valid = ($urandom_range(0, 2) != 0);
        bus.req1_a = rand_op(); bus.req1_b = rand_op();
        bus.req1_tag = TAG_W'($urandom_range(0, (1 << TAG_W) - 1));
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
